// File: rtl/conv_accum.sv
// conv_accum: N_TAPS-term signed Q8.8 multiply-accumulate with Q8.8 bias and a saturating Q8.8 output.
// Optional macro CONV_ACCUM_RELU_EN clamps negative results to zero.
`default_nettype none

module conv_accum #(
   parameter int N_TAPS = 9,
   parameter int ACC_W  = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [15:0] bias,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_sat
);

   localparam int CNT_W = $clog2(N_TAPS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_OUTPUT = 2'd2;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

   logic [1:0]              r_state;
   logic [1:0]              w_next_state;
   logic [CNT_W-1:0]        r_count;
   logic [CNT_W-1:0]        w_count_next;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_base;
   logic signed [ACC_W-1:0] w_acc_next;
   logic signed [ACC_W-1:0] w_shifted;
   logic signed [31:0]      w_prod;
   logic                    w_beat;
   logic                    w_last;
   logic [15:0]             w_res;
   logic                    w_sat;

   assign w_beat = in_valid & in_ready;
   assign w_prod = $signed(in_a) * $signed(in_b);

   // The first beat of a vector seeds the accumulator with the bias aligned to Q16.16.
   assign w_base       = (r_state == S_IDLE) ? $signed({{(ACC_W-24){bias[15]}}, bias, 8'h00}) : r_acc;
   assign w_acc_next   = w_base + $signed({{(ACC_W-32){w_prod[31]}}, w_prod});
   assign w_count_next = (r_state == S_IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
   assign w_last       = (w_count_next == CNT_W'(N_TAPS));
   assign w_shifted    = w_acc_next >>> 8;

   always_comb begin
      w_res = w_shifted[15:0];
      w_sat = 1'b0;
      if (w_shifted > SAT_MAX) begin
         w_res = 16'h7FFF;
         w_sat = 1'b1;
      end else if (w_shifted < SAT_MIN) begin
         w_res = 16'h8000;
         w_sat = 1'b1;
      end
`ifdef CONV_ACCUM_RELU_EN
      if (w_shifted[ACC_W-1]) begin
         w_res = 16'h0000;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_beat) w_next_state = w_last ? S_OUTPUT : S_ACCUM;
         S_ACCUM:  if (w_beat && w_last) w_next_state = S_OUTPUT;
         S_OUTPUT: if (out_ready) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // in_ready is forced low while reset is asserted, since the state alone reads IDLE then.
   always_comb begin
      in_ready  = (r_state != S_OUTPUT) && !rst;
      out_valid = (r_state == S_OUTPUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_count  <= '0;
         out_data <= 16'h0000;
         out_sat  <= 1'b0;
      end else if (w_beat) begin
         r_acc   <= w_acc_next;
         r_count <= w_last ? '0 : w_count_next;
         if (w_last) begin
            out_data <= w_res;
            out_sat  <= w_sat;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_accum.sv
// tb_conv_accum: directed vectors with hand-computed results for conv_accum (N_TAPS=9 and N_TAPS=1).
`default_nettype none

module tb_conv_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, out_sat;
   logic [15:0] in_a, in_b, bias, out_data;
   logic        in_valid1, in_ready1, out_valid1, out_ready1, out_sat1;
   logic [15:0] in_a1, in_b1, bias1, out_data1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   conv_accum #(.N_TAPS(9), .ACC_W(40)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .bias(bias), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );

   conv_accum #(.N_TAPS(1), .ACC_W(40)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .bias(bias1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1), .out_sat(out_sat1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   // Nine beats; bias_later is driven on beats 2..9 and during gaps.
   task automatic run_vector(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] bias0, input logic [15:0] bias_later,
                             input int gap);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 8) check("pre_valid", out_valid, 0);
         in_valid = 1'b1;
         in_a     = a;
         in_b     = b;
         bias     = (i == 0) ? bias0 : bias_later;
         if (gap > 0 && i < 8) begin
            @(negedge clk);
            in_valid = 1'b0;
            bias     = bias_later;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [15:0] exp_data, input logic exp_sat);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp_data);
      check({tag, "_sat"}, out_sat, exp_sat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle_valid"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_neg;
      logic [15:0] exp_min;
      logic [15:0] exp_tiny;
`ifdef CONV_ACCUM_RELU_EN
      exp_neg  = 16'h0000;
      exp_min  = 16'h0000;
      exp_tiny = 16'h0000;
`else
      exp_neg  = 16'hF940;
      exp_min  = 16'h8000;
      exp_tiny = 16'hFFFF;
`endif
      rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; bias = 0; out_ready = 0;
      in_valid1 = 0; in_a1 = 0; in_b1 = 0; bias1 = 0; out_ready1 = 0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_out_sat", out_sat, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("post_rst_ready", in_ready, 1);

      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0);
      expect_result("basic", 16'h1280, 1'b0);

      run_vector(16'hFE80, 16'h0080, 16'h0000, 16'h0000, 0);
      expect_result("neg", exp_neg, 1'b0);

      run_vector(16'h6400, 16'h6400, 16'h0000, 16'h0000, 0);
      expect_result("sat_pos", 16'h7FFF, 1'b1);
      run_vector(16'h6400, 16'h9C00, 16'h0000, 16'h0000, 0);
      expect_result("sat_neg", exp_min, 1'b1);

      // Backpressure: offered operands during the stall must be ignored.
      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = 16'h7FFF;
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 16'h1280);
         check("stall_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      expect_result("stall_release", 16'h1280, 1'b0);
      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0);
      expect_result("after_stall", 16'h1280, 1'b0);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0200; bias = 16'h0080;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0);
      expect_result("after_rst", 16'h1280, 1'b0);

      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0);
      #2 rst = 1'b1;
      #1 check("outrst_valid", out_valid, 0);
      check("outrst_data", out_data, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      run_vector(16'h0100, 16'h0200, 16'h0080, 16'h7F00, 3);
      expect_result("gaps", 16'h1280, 1'b0);

      @(negedge clk);
      in_valid1 = 1'b1; in_a1 = 16'h0100; in_b1 = 16'h0300; bias1 = 16'h0100;
      @(negedge clk);
      in_valid1 = 1'b0;
      check("n1_valid", out_valid1, 1);
      check("n1_data", out_data1, 16'h0400);
      check("n1_ready", in_ready1, 0);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("n1_idle", out_valid1, 0);
      in_valid1 = 1'b1; in_a1 = 16'h0001; in_b1 = 16'hFFFF; bias1 = 16'h0000;
      @(negedge clk);
      in_valid1 = 1'b0;
      check("trunc_data", out_data1, exp_tiny);
      check("trunc_sat", out_sat1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
